countdown_sched: RTL and testbench

Round-robin scheduler that shares one WIDTH-bit down-counter between N_REQ requesters. Each requester presents a load value and holds a request. The block grants the counter to one requester at a time, loads and decrements the count to zero, and pulses that requester's done flag. It sits in front of the counter datapath as its sole sequencer; requesters never drive the counter directly.

---
 rtl/countdown_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/countdown_sched.sv | 102 ++++++++++
 tb/tb_countdown_sched.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types and defaults for the countdown scheduler and its arbiter.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after the pointer wins.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_winner,
  output logic [IDX_W-1:0] o_idx
);

  logic w_found;

  // Walk the requesters starting at the pointer, wrapping modulo N_REQ.
  always_comb begin
    w_found  = 1'b0;
    o_winner = '0;
    o_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && i_req[(int'(i_ptr) + k) % N_REQ]) begin
        w_found  = 1'b1;
        o_idx    = IDX_W'((int'(i_ptr) + k) % N_REQ);
        o_winner = N_REQ'(1) << ((int'(i_ptr) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/countdown_sched.sv
// Round-robin sequencer sharing one down-counter among N_REQ requesters.
module countdown_sched
  import countdown_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_load,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic [WIDTH-1:0]       cnt,
  output logic [N_REQ-1:0]       done
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_done;
  logic             r_busy;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_idx;

  logic [N_REQ-1:0] w_winner;
  logic [IDX_W-1:0] w_winnerIdx;
  logic [WIDTH-1:0] w_load;
  logic [IDX_W-1:0] w_ptrNext;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_idx    (w_winnerIdx)
  );

  assign w_load    = req_load[int'(w_winnerIdx)*WIDTH +: WIDTH];
  assign w_ptrNext = (w_winnerIdx == IDX_W'(N_REQ-1)) ? '0 : w_winnerIdx + 1'b1;

  // Zero is tested before decrementing, so the counter never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_ptr   <= '0;
      r_idx   <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_state <= ST_COUNT;
            r_gnt   <= w_winner;
            r_idx   <= w_winnerIdx;
            r_cnt   <= w_load;
            r_ptr   <= w_ptrNext;
            r_busy  <= 1'b1;
          end
        end
        ST_COUNT: begin
          if (!req[r_idx]) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state <= ST_DONE;
            r_done  <= r_gnt;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt  = r_gnt;
  assign busy = r_busy;
  assign cnt  = r_cnt;
  assign done = r_done;

endmodule

// File: tb/tb_countdown_sched.sv
// Self-checking bench for countdown_sched: vector table, corner sequences, randomized model run.
module tb_countdown_sched;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk;
  logic           rstN;
  logic [N-1:0]   req;
  logic [N*W-1:0] reqLoad;
  logic [N-1:0]   gnt;
  logic           busy;
  logic [W-1:0]   cnt;
  logic [N-1:0]   done;

  int checks = 0;
  int errors = 0;

  countdown_sched #(.N_REQ(N), .WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rstN),
    .req      (req),
    .req_load (reqLoad),
    .gnt      (gnt),
    .busy     (busy),
    .cnt      (cnt),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] load;
    logic [N-1:0]   gnt;
    logic [W-1:0]   cnt;
    logic           busy;
    logic [N-1:0]   done;
  } vec_t;

  vec_t vecs [10];

  // Reference model: a job is described by owner, load and edges since the grant.
  int mJob, mOwner, mLoad, mT, mPtr;

  task automatic modelReset();
    mJob = 0; mOwner = 0; mLoad = 0; mT = 0; mPtr = 0;
  endtask

  task automatic modelEdge(input logic [N-1:0] r, input logic [N*W-1:0] ld);
    int found;
    if (mJob == 0) begin
      if (r != 0) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          if (found == 0 && r[(mPtr + k) % N]) begin
            found  = 1;
            mOwner = (mPtr + k) % N;
          end
        end
        mLoad = int'(ld[mOwner*W +: W]);
        mT    = 0;
        mJob  = 1;
        mPtr  = (mOwner + 1) % N;
      end
    end else if (mT <= mLoad) begin
      if (!r[mOwner]) mJob = 0;
      else mT = mT + 1;
    end else begin
      mJob = 0;
    end
  endtask

  task automatic checkOutput(input string name, input logic [N-1:0] eGnt, input logic [W-1:0] eCnt,
                             input logic eBusy, input logic [N-1:0] eDone);
    checks++;
    if (gnt !== eGnt) begin
      errors++;
      $display("[TB] FAIL %s gnt: got %b expected %b", name, gnt, eGnt);
    end
    checks++;
    if (cnt !== eCnt) begin
      errors++;
      $display("[TB] FAIL %s cnt: got %0d expected %0d", name, cnt, eCnt);
    end
    checks++;
    if (busy !== eBusy) begin
      errors++;
      $display("[TB] FAIL %s busy: got %b expected %b", name, busy, eBusy);
    end
    checks++;
    if (done !== eDone) begin
      errors++;
      $display("[TB] FAIL %s done: got %b expected %b", name, done, eDone);
    end
  endtask

  task automatic checkModel(input string name);
    logic [N-1:0] eGnt;
    logic [W-1:0] eCnt;
    eGnt = (mJob != 0) ? N'(1) << mOwner : '0;
    eCnt = (mJob != 0 && mT <= mLoad) ? W'(mLoad - mT) : '0;
    checkOutput(name, eGnt, eCnt, mJob != 0, (mJob != 0 && mT == mLoad + 1) ? eGnt : '0);
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N*W-1:0] ld);
    req     = r;
    reqLoad = ld;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    req     = '0;
    reqLoad = '0;
    rstN    = 1'b0;
    #3;
    checkOutput("reset", '0, '0, 1'b0, '0);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  initial begin
    rstN    = 1'b1;
    req     = '0;
    reqLoad = '0;
    #2;

    vecs[0] = '{4'b0001, 16'h0003, 4'b0001, 4'd3, 1'b1, 4'b0000};
    vecs[1] = '{4'b0001, 16'h0003, 4'b0001, 4'd2, 1'b1, 4'b0000};
    vecs[2] = '{4'b0001, 16'h0003, 4'b0001, 4'd1, 1'b1, 4'b0000};
    vecs[3] = '{4'b0001, 16'h0003, 4'b0001, 4'd0, 1'b1, 4'b0000};
    vecs[4] = '{4'b0001, 16'h0003, 4'b0001, 4'd0, 1'b1, 4'b0001};
    vecs[5] = '{4'b0000, 16'h0000, 4'b0000, 4'd0, 1'b0, 4'b0000};
    vecs[6] = '{4'b0000, 16'h0000, 4'b0000, 4'd0, 1'b0, 4'b0000};
    vecs[7] = '{4'b0100, 16'hF0FF, 4'b0100, 4'd0, 1'b1, 4'b0000};
    vecs[8] = '{4'b0100, 16'hF0FF, 4'b0100, 4'd0, 1'b1, 4'b0100};
    vecs[9] = '{4'b0000, 16'h0000, 4'b0000, 4'd0, 1'b0, 4'b0000};

    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].req, vecs[i].load);
      checkOutput($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].cnt, vecs[i].busy, vecs[i].done);
    end

    // Round robin with all requesters held and every load = 1.
    doReset();
    for (int j = 0; j < 5; j++) begin
      applyStimulus(4'b1111, 16'h1111);
      checkOutput($sformatf("rr%0d_grant", j), 4'(1 << (j % N)), 4'd1, 1'b1, 4'b0000);
      applyStimulus(4'b1111, 16'h1111);
      checkOutput($sformatf("rr%0d_zero", j), 4'(1 << (j % N)), 4'd0, 1'b1, 4'b0000);
      applyStimulus(4'b1111, 16'h1111);
      checkOutput($sformatf("rr%0d_done", j), 4'(1 << (j % N)), 4'd0, 1'b1, 4'(1 << (j % N)));
      applyStimulus(4'b1111, 16'h1111);
      checkOutput($sformatf("rr%0d_idle", j), 4'b0000, 4'd0, 1'b0, 4'b0000);
    end

    // Abort: requester 1 drops while cnt = 2; pointer must remain at 2.
    doReset();
    applyStimulus(4'b0010, 16'h0040);
    checkOutput("abort_grant", 4'b0010, 4'd4, 1'b1, 4'b0000);
    applyStimulus(4'b0010, 16'h0040);
    applyStimulus(4'b0010, 16'h0040);
    checkOutput("abort_cnt2", 4'b0010, 4'd2, 1'b1, 4'b0000);
    applyStimulus(4'b0000, 16'h0040);
    checkOutput("abort_idle", 4'b0000, 4'd0, 1'b0, 4'b0000);
    applyStimulus(4'b1111, 16'h2222);
    checkOutput("abort_ptr", 4'b0100, 4'd2, 1'b1, 4'b0000);

    // Asynchronous reset in the middle of a count.
    doReset();
    applyStimulus(4'b0001, 16'h0005);
    checkOutput("midrst_grant", 4'b0001, 4'd5, 1'b1, 4'b0000);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midrst_async", 4'b0000, 4'd0, 1'b0, 4'b0000);
    req = 4'b1111;
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(4'b1111, 16'h3333);
    checkOutput("midrst_prio", 4'b0001, 4'd3, 1'b1, 4'b0000);

    // Load changes after the grant edge are ignored.
    doReset();
    applyStimulus(4'b0010, 16'h0040);
    checkOutput("ldchg_grant", 4'b0010, 4'd4, 1'b1, 4'b0000);
    for (int c = 3; c >= 0; c--) begin
      applyStimulus(4'b0010, 16'h0090);
      checkOutput($sformatf("ldchg_cnt%0d", c), 4'b0010, W'(c), 1'b1, 4'b0000);
    end
    applyStimulus(4'b0010, 16'h0090);
    checkOutput("ldchg_done", 4'b0010, 4'd0, 1'b1, 4'b0010);

    // Randomized run against the reference model.
    doReset();
    modelReset();
    begin
      logic [N-1:0]   r;
      logic [N*W-1:0] ld;
      r = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        if ($urandom_range(0, 5) == 0) r[$urandom_range(0, N-1)] = ~r[$urandom_range(0, N-1)];
        if ($urandom_range(0, 9) == 0) r = 4'($urandom);
        for (int b = 0; b < N; b++) ld[b*W +: W] = W'($urandom_range(0, 5));
        modelEdge(r, ld);
        applyStimulus(r, ld);
        checkModel($sformatf("rand%0d", cyc));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
